chroma8x8_mode_decision: RTL and testbench

Downstream consumer of the 8x8 chroma intra predictor. It latches one 8x8 block of original chroma samples and the vertical, horizontal and DC prediction blocks the predictor produces. Over eight cycles it accumulates one row per cycle of sum-of-absolute-differences (SAD) per mode, then reports the lowest-cost mode and its SAD. It sits between the chroma predictor and the residual/transform stage, which uses `best_mode` to pick the prediction to subtract.

---
 rtl/chroma8x8_mode_decision.sv | 165 ++++++++++++++++
 tb/tb_chroma8x8_mode_decision.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma8x8_mode_decision.sv
// Chroma 8x8 intra mode decision: latches one original block plus V/H/DC predictions,
// accumulates per-mode SAD one row per cycle, then reports the cheapest mode.
module chroma8x8_mode_decision (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0][7:0] origpixels,
    input  logic [63:0][7:0] vpred,
    input  logic [63:0][7:0] hpred,
    input  logic [63:0][7:0] dcpred,
    output logic             busy,
    output logic             done,
    output logic [1:0]       best_mode,
    output logic [13:0]      best_sad,
    output logic [13:0]      sad_dc,
    output logic [13:0]      sad_h,
    output logic [13:0]      sad_v
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StCmp
    } state_e;

    localparam logic [1:0] ModeDc = 2'd0;
    localparam logic [1:0] ModeH  = 2'd1;
    localparam logic [1:0] ModeV  = 2'd2;

    state_e state_q, state_d;

    logic [63:0][7:0] orig_q, v_q, h_q, dc_q;
    logic             latch_en;
    logic             res_en;

    logic [2:0]  row_q, row_d;
    logic [13:0] acc_dc_q, acc_dc_d;
    logic [13:0] acc_h_q, acc_h_d;
    logic [13:0] acc_v_q, acc_v_d;
    logic [10:0] row_dc, row_h, row_v;

    logic [1:0]  min_mode;
    logic [13:0] min_sad;

    logic        done_q;
    logic [1:0]  best_mode_q;
    logic [13:0] best_sad_q, sad_dc_q, sad_h_q, sad_v_q;

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Row sums for the row currently addressed by row_q.
    always_comb begin
        row_dc = '0;
        row_h  = '0;
        row_v  = '0;
        for (int c = 0; c < 8; c++) begin
            row_dc = row_dc + 11'(absdiff(orig_q[{row_q, 3'(c)}], dc_q[{row_q, 3'(c)}]));
            row_h  = row_h  + 11'(absdiff(orig_q[{row_q, 3'(c)}], h_q[{row_q, 3'(c)}]));
            row_v  = row_v  + 11'(absdiff(orig_q[{row_q, 3'(c)}], v_q[{row_q, 3'(c)}]));
        end
    end

    // Strict less-than keeps the earlier candidate on ties (DC, then H, then V).
    always_comb begin
        min_mode = ModeDc;
        min_sad  = acc_dc_q;
        if (acc_h_q < min_sad) begin
            min_mode = ModeH;
            min_sad  = acc_h_q;
        end
        if (acc_v_q < min_sad) begin
            min_mode = ModeV;
            min_sad  = acc_v_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        acc_dc_d = acc_dc_q;
        acc_h_d  = acc_h_q;
        acc_v_d  = acc_v_q;
        latch_en = 1'b0;
        res_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    latch_en = 1'b1;
                    row_d    = '0;
                    acc_dc_d = '0;
                    acc_h_d  = '0;
                    acc_v_d  = '0;
                    state_d  = StAccum;
                end
            end
            StAccum: begin
                acc_dc_d = acc_dc_q + 14'(row_dc);
                acc_h_d  = acc_h_q + 14'(row_h);
                acc_v_d  = acc_v_q + 14'(row_v);
                row_d    = row_q + 3'd1;
                if (row_q == 3'd7) begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
                res_en  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            row_q       <= '0;
            acc_dc_q    <= '0;
            acc_h_q     <= '0;
            acc_v_q     <= '0;
            done_q      <= 1'b0;
            best_mode_q <= ModeDc;
            best_sad_q  <= '0;
            sad_dc_q    <= '0;
            sad_h_q     <= '0;
            sad_v_q     <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            acc_dc_q <= acc_dc_d;
            acc_h_q  <= acc_h_d;
            acc_v_q  <= acc_v_d;
            done_q   <= res_en;
            if (res_en) begin
                best_mode_q <= min_mode;
                best_sad_q  <= min_sad;
                sad_dc_q    <= acc_dc_q;
                sad_h_q     <= acc_h_q;
                sad_v_q     <= acc_v_q;
            end
        end
    end

    // Sample storage is only meaningful after a start, so it carries no reset.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            orig_q <= origpixels;
            v_q    <= vpred;
            h_q    <= hpred;
            dc_q   <= dcpred;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;
    assign sad_dc    = sad_dc_q;
    assign sad_h     = sad_h_q;
    assign sad_v     = sad_v_q;

endmodule

// File: tb/tb_chroma8x8_mode_decision.sv
// Self-checking bench for chroma8x8_mode_decision: per-scenario tasks, results
// predicted by a per-sample SAD model and queued at start, popped on done.
module tb_chroma8x8_mode_decision;

    typedef logic [63:0][7:0] blk_t;
    typedef struct packed {
        logic [1:0]  mode;
        logic [13:0] best;
        logic [13:0] sdc;
        logic [13:0] sh;
        logic [13:0] sv;
    } res_t;

    logic        clk;
    logic        reset;
    logic        start;
    blk_t        origpixels, vpred, hpred, dcpred;
    logic        busy, done;
    logic [1:0]  best_mode;
    logic [13:0] best_sad, sad_dc, sad_h, sad_v;

    int   checks;
    int   errors;
    res_t exp_q[$];

    chroma8x8_mode_decision dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .origpixels (origpixels),
        .vpred      (vpred),
        .hpred      (hpred),
        .dcpred     (dcpred),
        .busy       (busy),
        .done       (done),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .sad_dc     (sad_dc),
        .sad_h      (sad_h),
        .sad_v      (sad_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic blk_t fill(input logic [7:0] val);
        blk_t b;
        for (int i = 0; i < 64; i++) b[i] = val;
        return b;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < 64; i++) b[i] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    function automatic int sad_of(input blk_t o, input blk_t p);
        int s = 0;
        for (int i = 0; i < 64; i++) begin
            int d = int'(o[i]) - int'(p[i]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    function automatic res_t model(input blk_t o, input blk_t v, input blk_t h, input blk_t dc);
        res_t r;
        r.sdc  = 14'(sad_of(o, dc));
        r.sh   = 14'(sad_of(o, h));
        r.sv   = 14'(sad_of(o, v));
        r.mode = 2'd0;
        r.best = r.sdc;
        if (r.sh < r.best) begin r.mode = 2'd1; r.best = r.sh; end
        if (r.sv < r.best) begin r.mode = 2'd2; r.best = r.sv; end
        return r;
    endfunction

    // Called at #1 after a rising edge with the DUT idle; returns at #1 after E0.
    task automatic start_block(input blk_t o, input blk_t v, input blk_t h, input blk_t dc);
        origpixels = o;
        vpred      = v;
        hpred      = h;
        dcpred     = dc;
        start      = 1'b1;
        exp_q.push_back(model(o, v, h, dc));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 40);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        origpixels = '0;
        vpred = '0;
        hpred = '0;
        dcpred = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, best_mode, best_sad, sad_dc, sad_h, sad_v} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b done=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want all 0",
                     busy, done, best_mode, best_sad, sad_dc, sad_h, sad_v);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_flat();
        int   cyc;
        res_t e;
        start_block(fill(8'd128), fill(8'd128), fill(8'd128), fill(8'd128));
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flat_busy_after_start: got %0b, want 1", busy);
        end
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL flat_latency: got %0d cycles, want 9", cyc);
        end
        checks++;
        if ({busy, best_mode, best_sad, sad_dc, sad_h, sad_v} !== {1'b0, e}) begin
            errors++;
            $display("FAIL flat_result: got busy=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want busy=0 mode=%0d best=%0d dc=%0d h=%0d v=%0d",
                     busy, best_mode, best_sad, sad_dc, sad_h, sad_v, e.mode, e.best, e.sdc, e.sh, e.sv);
        end
        checks++;
        if ({best_mode, sad_dc, sad_h, sad_v} !== '0) begin
            errors++;
            $display("FAIL flat_zero_sads: got mode=%0d dc=%0d h=%0d v=%0d, want all 0",
                     best_mode, sad_dc, sad_h, sad_v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL flat_done_one_cycle: got %0b, want 0", done);
        end
    endtask

    task automatic test_vertical();
        int   cyc;
        res_t e;
        blk_t o;
        for (int i = 0; i < 64; i++) o[i] = 8'(16 * (i % 8));
        start_block(o, o, fill(8'd0), fill(8'd112));
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if ({busy, best_mode, best_sad, sad_dc, sad_h, sad_v} !== {1'b0, e}) begin
            errors++;
            $display("FAIL vertical_result: got busy=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want busy=0 mode=%0d best=%0d dc=%0d h=%0d v=%0d",
                     busy, best_mode, best_sad, sad_dc, sad_h, sad_v, e.mode, e.best, e.sdc, e.sh, e.sv);
        end
        // Each row is 0,16,..,112: sum 448 against 0 and against 112, times 8 rows.
        checks++;
        if ({best_mode, best_sad, sad_v, sad_h, sad_dc} !== {2'd2, 14'd0, 14'd0, 14'd3584, 14'd3584}) begin
            errors++;
            $display("FAIL vertical_values: got mode=%0d best=%0d v=%0d h=%0d dc=%0d, want mode=2 best=0 v=0 h=3584 dc=3584",
                     best_mode, best_sad, sad_v, sad_h, sad_dc);
        end
    endtask

    task automatic test_max();
        int   cyc;
        res_t e;
        start_block(fill(8'd255), fill(8'd0), fill(8'd0), fill(8'd0));
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if ({busy, best_mode, best_sad, sad_dc, sad_h, sad_v} !== {1'b0, e}) begin
            errors++;
            $display("FAIL max_result: got busy=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want busy=0 mode=%0d best=%0d dc=%0d h=%0d v=%0d",
                     busy, best_mode, best_sad, sad_dc, sad_h, sad_v, e.mode, e.best, e.sdc, e.sh, e.sv);
        end
        checks++;
        if ({sad_dc, sad_h, sad_v} !== {14'd16320, 14'd16320, 14'd16320}) begin
            errors++;
            $display("FAIL max_no_wrap: got dc=%0d h=%0d v=%0d, want 16320 each", sad_dc, sad_h, sad_v);
        end
    endtask

    task automatic test_tie();
        int   cyc;
        res_t e;
        start_block(fill(8'd10), fill(8'd8), fill(8'd12), fill(8'd20));
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if ({busy, best_mode, best_sad, sad_dc, sad_h, sad_v} !== {1'b0, e}) begin
            errors++;
            $display("FAIL tie_result: got busy=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want busy=0 mode=%0d best=%0d dc=%0d h=%0d v=%0d",
                     busy, best_mode, best_sad, sad_dc, sad_h, sad_v, e.mode, e.best, e.sdc, e.sh, e.sv);
        end
        checks++;
        if ({best_mode, sad_h, sad_v, sad_dc} !== {2'd1, 14'd128, 14'd128, 14'd640}) begin
            errors++;
            $display("FAIL tie_h_over_v: got mode=%0d h=%0d v=%0d dc=%0d, want mode=1 h=128 v=128 dc=640",
                     best_mode, sad_h, sad_v, sad_dc);
        end
    endtask

    task automatic test_start_while_busy();
        int   ndone = 0;
        int   first = 0;
        res_t e;
        start_block(rand_blk(), rand_blk(), rand_blk(), rand_blk());
        // Upstream changes its arrays right after the start edge.
        origpixels = rand_blk();
        vpred      = rand_blk();
        hpred      = rand_blk();
        dcpred     = rand_blk();
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (ndone !== 1 || first !== 5) begin
            errors++;
            $display("FAIL busy_single_done: got %0d done pulses (first at E%0d), want 1 at E9",
                     ndone, first + 4);
        end
        checks++;
        if ({busy, best_mode, best_sad, sad_dc, sad_h, sad_v} !== {1'b0, e}) begin
            errors++;
            $display("FAIL busy_result: got busy=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want busy=0 mode=%0d best=%0d dc=%0d h=%0d v=%0d",
                     busy, best_mode, best_sad, sad_dc, sad_h, sad_v, e.mode, e.best, e.sdc, e.sh, e.sv);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        res_t e;
        start_block(rand_blk(), rand_blk(), rand_blk(), rand_blk());
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if ({busy, best_mode, best_sad, sad_dc, sad_h, sad_v} !== {1'b0, e}) begin
            errors++;
            $display("FAIL b2b_first_result: got busy=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want busy=0 mode=%0d best=%0d dc=%0d h=%0d v=%0d",
                     busy, best_mode, best_sad, sad_dc, sad_h, sad_v, e.mode, e.best, e.sdc, e.sh, e.sv);
        end
        // Start is raised during the done cycle and must be taken at E10.
        start_block(rand_blk(), rand_blk(), rand_blk(), rand_blk());
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%0b done=%0b, want busy=1 done=0", busy, done);
        end
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL b2b_latency: got %0d cycles, want 9", cyc);
        end
        checks++;
        if ({busy, best_mode, best_sad, sad_dc, sad_h, sad_v} !== {1'b0, e}) begin
            errors++;
            $display("FAIL b2b_second_result: got busy=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want busy=0 mode=%0d best=%0d dc=%0d h=%0d v=%0d",
                     busy, best_mode, best_sad, sad_dc, sad_h, sad_v, e.mode, e.best, e.sdc, e.sh, e.sv);
        end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        int   ndone = 0;
        res_t e;
        blk_t o;
        start_block(fill(8'd10), fill(8'd8), fill(8'd12), fill(8'd20));
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, best_mode, best_sad, sad_dc, sad_h, sad_v} !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear: got busy=%0b done=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want all 0",
                     busy, done, best_mode, best_sad, sad_dc, sad_h, sad_v);
        end
        void'(exp_q.pop_front());
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        reset = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", ndone);
        end
        for (int i = 0; i < 64; i++) o[i] = 8'(16 * (i % 8));
        start_block(o, o, fill(8'd0), fill(8'd112));
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL reset_mid_restart_latency: got %0d cycles, want 9", cyc);
        end
        checks++;
        if ({busy, best_mode, best_sad, sad_dc, sad_h, sad_v} !== {1'b0, e}) begin
            errors++;
            $display("FAIL reset_mid_restart_result: got busy=%0b mode=%0d best=%0d dc=%0d h=%0d v=%0d, want busy=0 mode=%0d best=%0d dc=%0d h=%0d v=%0d",
                     busy, best_mode, best_sad, sad_dc, sad_h, sad_v, e.mode, e.best, e.sdc, e.sh, e.sv);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_flat();
        test_vertical();
        test_max();
        test_tie();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
